// File: rtl/uart_frame_piso.sv
// uart_frame_piso: UART frame serializer (start, 8 data LSB-first, optional parity, 1-2 stop bits).
module uart_frame_piso (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       parity_in,
  input  logic       stop_bits,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ptype_q, ptype_d;
  logic       par_q, par_d;
  logic       stop2_q, stop2_d;
  logic       tx_d, busy_d, done_d;
  logic       par_en;
  assign par_en = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ptype_q <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ptype_q <= ptype_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_out  <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end
  // Outputs are derived from the next state so they line up with the registered state.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    ptype_d = ptype_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        data_d  = data_in;
        ptype_d = parity_type;
        par_d   = parity_in;
        stop2_d = stop_bits;
        state_d = START;
      end
      START: if (baud_tick) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_tick) begin
        bit_d  = bit_q + 3'd1;
        stop_d = 1'b0;
        if (bit_q == 3'd7) state_d = par_en ? PARITY : STOP;
      end
      PARITY: if (baud_tick) begin
        stop_d  = 1'b0;
        state_d = STOP;
      end
      STOP: if (baud_tick) begin
        if (stop_q || !stop2_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d   = (state_d == START)  ? 1'b0 :
             (state_d == DATA)   ? data_d[bit_d] :
             (state_d == PARITY) ? par_d : 1'b1;
    busy_d = state_d != IDLE;
  end
endmodule

// File: tb/tb_uart_frame_piso.sv
// tb_uart_frame_piso: table-driven and randomized frame checks against a bit-queue model.
module tb_uart_frame_piso;
  logic       clk = 0, rst = 1, baud_tick = 0, send = 0;
  logic [7:0] data_in = 0;
  logic [1:0] parity_type = 0;
  logic       parity_in = 0, stop_bits = 0;
  logic       tx_out, busy, done;
  int n_cmp = 0, n_bad = 0;
  bit exp_q[$];
  int idx = 0, bit_err = 0, done_cnt = 0, tcnt = 0;
  bit mon_on = 0;
  typedef struct {
    logic [7:0] d;
    logic [1:0] pt;
    logic       pi;
    logic       s2;
    int         len;
    bit         noise;
  } vec_t;
  vec_t tbl[5];

  uart_frame_piso dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .send(send), .data_in(data_in),
    .parity_type(parity_type), .parity_in(parity_in), .stop_bits(stop_bits),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    tcnt++;
    baud_tick = (tcnt % 4 == 0);
  end

  // Walk the expected bit queue: every busy cycle must show the current bit; a tick ends it.
  always @(negedge clk) if (mon_on) begin
    if (busy) begin
      if (idx >= exp_q.size() || tx_out !== exp_q[idx]) bit_err++;
      if (baud_tick) idx++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic arm(input logic [7:0] d, input logic [1:0] pt, input logic pi, input logic s2);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pt == 2'b01 || pt == 2'b10) exp_q.push_back(pi);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
    idx = 0;
    bit_err = 0;
    done_cnt = 0;
    mon_on = 1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] pt, input logic pi, input logic s2);
    data_in = d;
    parity_type = pt;
    parity_in = pi;
    stop_bits = s2;
  endtask

  task automatic wait_end(input string nm, input bit noise, input bit hold);
    int n = 0;
    while (busy && n < 100) begin
      if (noise) begin
        data_in = 8'($urandom);
        parity_type = 2'($urandom);
        parity_in = 1'($urandom);
        stop_bits = 1'($urandom);
        send = 1'($urandom);
      end else send = hold;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hold) send = 0;
    chk({nm, "_timeout"}, int'(busy), 0);
  endtask

  task automatic check_end(input string nm, input int len, input bit hold);
    @(negedge clk);
    #1;
    if (!hold) begin
      @(negedge clk);
      #1;
      chk({nm, "_idle_busy"}, int'(busy), 0);
    end
    chk({nm, "_bits"}, bit_err, 0);
    chk({nm, "_len"}, idx, len);
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_tx_idle"}, int'(tx_out), 1);
    mon_on = 0;
  endtask

  task automatic run(input string nm, input logic [7:0] d, input logic [1:0] pt, input logic pi,
                     input logic s2, input int len, input bit noise);
    @(posedge clk);
    #1;
    drive(d, pt, pi, s2);
    send = 1;
    @(posedge clk);
    #1;
    arm(d, pt, pi, s2);
    chk({nm, "_start_busy"}, int'(busy), 1);
    chk({nm, "_start_tx"}, int'(tx_out), 0);
    wait_end(nm, noise, 0);
    check_end(nm, len, 0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 2'b10, 1'b0, 1'b0, 11, 1'b0};
    tbl[1] = '{8'h00, 2'b01, 1'b1, 1'b1, 12, 1'b0};
    tbl[2] = '{8'hFF, 2'b00, 1'b0, 1'b0, 10, 1'b1};
    tbl[3] = '{8'h96, 2'b11, 1'b1, 1'b1, 11, 1'b1};
    tbl[4] = '{8'h81, 2'b01, 1'b1, 1'b0, 11, 1'b1};
    #1 rst = 0;
    #2;
    chk("rst_tx", int'(tx_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    begin
      int bad = 0;
      repeat (12) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("idle_ticks", bad, 0);
    end
    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i].d, tbl[i].pt, tbl[i].pi, tbl[i].s2, tbl[i].len, tbl[i].noise);
    // Abort mid-frame during data bit 5.
    @(posedge clk);
    #1;
    drive(8'h5A, 2'b10, 1'b0, 1'b0);
    send = 1;
    @(posedge clk);
    #1;
    send = 0;
    arm(8'h5A, 2'b10, 1'b0, 1'b0);
    begin
      int n = 0;
      while (idx < 6 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("abort_reach_bit5", idx, 6);
    end
    #2 rst = 0;
    #1;
    chk("abort_tx", int'(tx_out), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_stays_idle", int'(busy), 0);
    mon_on = 0;
    run("post_abort", 8'h5A, 2'b10, 1'b0, 1'b0, 11, 1'b0);
    // Back-to-back with send held high.
    @(posedge clk);
    #1;
    drive(8'hC3, 2'b10, 1'b0, 1'b1);
    send = 1;
    @(posedge clk);
    #1;
    arm(8'hC3, 2'b10, 1'b0, 1'b1);
    wait_end("b2b1", 0, 1);
    check_end("b2b1", 12, 1);
    @(posedge clk);
    #1;
    chk("b2b_gap_busy", int'(busy), 1);
    chk("b2b_gap_tx", int'(tx_out), 0);
    arm(8'hC3, 2'b10, 1'b0, 1'b1);
    send = 0;
    wait_end("b2b2", 0, 0);
    check_end("b2b2", 12, 0);
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      logic [1:0] pt;
      logic pi, s2;
      d = 8'($urandom);
      pt = 2'($urandom);
      pi = 1'($urandom);
      s2 = 1'($urandom);
      run($sformatf("rnd%0d", k), d, pt, pi, s2, 10 + ((pt == 2'b01 || pt == 2'b10) ? 1 : 0) + int'(s2), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
